// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, handler vector and PRId value.
// The PRId register is present only when CP0_PRID_EN is defined.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] PRID_VALUE = 32'h0000_4220;

endpackage

// File: rtl/cp0_ctrl.sv
// CP0 status/cause/EPC block: raises req for interrupts and M-stage exceptions, serves mfc0/mtc0.
// Optional read-only PRId at register 15 when CP0_PRID_EN is defined.
module cp0_ctrl
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   output logic        req,
   output logic [31:0] epc_out
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_base;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign int_req  = ie & ~exl & (|(hw_int & im));
   assign exc_req  = (exc_code_in != EXC_INT) & ~exl;
   assign req      = int_req | exc_req;
   assign epc_base = bd_in ? (vpc - 32'd4) : vpc;
   assign epc_out  = epc;

   assign sr_val    = {16'd0, im, 8'd0, exl, ie};
   assign cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= hw_int;
         if (req) begin
            exl      <= 1'b1;
            bd       <= bd_in;
            exc_code <= int_req ? EXC_INT : exc_code_in;
            epc      <= {epc_base[31:2], 2'b00};
         end else begin
            if (en && cp0_addr == REG_SR) begin
               im  <= cp0_wdata[15:10];
               exl <= cp0_wdata[1];
               ie  <= cp0_wdata[0];
            end
            if (en && cp0_addr == REG_EPC)
               epc <= cp0_wdata;
            // eret is applied last so it wins over a same-edge SR write of EXL
            if (eret)
               exl <= 1'b0;
         end
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_addr)
         REG_SR:    cp0_rdata = sr_val;
         REG_CAUSE: cp0_rdata = cause_val;
         REG_EPC:   cp0_rdata = epc;
`ifdef CP0_PRID_EN
         REG_PRID:  cp0_rdata = PRID_VALUE;
`endif
         default:   cp0_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed table-driven bench for cp0_ctrl: each row drives one cycle, checks req before the edge
// and SR/Cause/EPC/epc_out after it.
module tb_cp0_ctrl;
   import cp0_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic        eret;
   logic [5:0]  hw_int;
   logic        req;
   logic [31:0] epc_out;

   int total = 0;
   int bad   = 0;

   cp0_ctrl dut (
      .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
      .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
      .eret(eret), .hw_int(hw_int), .req(req), .epc_out(epc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] vpc;
      logic        bd;
      logic [4:0]  exc;
      logic        eret;
      logic [5:0]  hw;
      logic        exp_req;
      logic [31:0] exp_sr;
      logic [31:0] exp_cause;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[19];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      en = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0; vpc = 32'd0;
      bd_in = 1'b0; exc_code_in = 5'd0; eret = 1'b0;
   endtask

   initial begin
      //          rst en addr   wdata          vpc           bd exc eret hw        req  sr             cause          epc
      vecs[0]  = '{1, 0, 5'd0,  32'd0,         32'd0,        0, 0,  0, 6'b000000, 0, 32'h0,         32'h0,         32'h0};
      vecs[1]  = '{0, 0, 5'd0,  32'd0,         32'h3010,     0, 12, 0, 6'b000000, 1, 32'h2,         32'h30,        32'h3010};
      vecs[2]  = '{0, 0, 5'd0,  32'd0,         32'h4000,     0, 10, 0, 6'b000000, 0, 32'h2,         32'h30,        32'h3010};
      vecs[3]  = '{0, 0, 5'd0,  32'd0,         32'd0,        0, 0,  1, 6'b000000, 0, 32'h0,         32'h30,        32'h3010};
      vecs[4]  = '{0, 0, 5'd0,  32'd0,         32'h3024,     1, 4,  0, 6'b000000, 1, 32'h2,         32'h8000_0010, 32'h3020};
      vecs[5]  = '{0, 0, 5'd0,  32'd0,         32'd0,        0, 0,  1, 6'b000000, 0, 32'h0,         32'h8000_0010, 32'h3020};
      vecs[6]  = '{0, 1, 5'd12, 32'h0000_0401, 32'd0,        0, 0,  0, 6'b000000, 0, 32'h401,       32'h8000_0010, 32'h3020};
      vecs[7]  = '{0, 0, 5'd0,  32'd0,         32'h5008,     0, 12, 0, 6'b000001, 1, 32'h403,       32'h400,       32'h5008};
      vecs[8]  = '{0, 0, 5'd0,  32'd0,         32'd0,        0, 0,  0, 6'b000001, 0, 32'h403,       32'h400,       32'h5008};
      vecs[9]  = '{0, 0, 5'd0,  32'd0,         32'd0,        0, 0,  1, 6'b000001, 0, 32'h401,       32'h400,       32'h5008};
      vecs[10] = '{0, 0, 5'd0,  32'd0,         32'h6000,     0, 0,  0, 6'b000001, 1, 32'h403,       32'h400,       32'h6000};
      vecs[11] = '{0, 1, 5'd12, 32'h0000_0400, 32'd0,        0, 0,  0, 6'b000001, 0, 32'h400,       32'h400,       32'h6000};
      vecs[12] = '{0, 0, 5'd0,  32'd0,         32'd0,        0, 0,  0, 6'b000001, 0, 32'h400,       32'h400,       32'h6000};
      vecs[13] = '{0, 1, 5'd12, 32'h0000_0001, 32'd0,        0, 0,  0, 6'b000000, 0, 32'h1,         32'h0,         32'h6000};
      vecs[14] = '{0, 1, 5'd14, 32'h0000_5000, 32'h7004,     0, 10, 0, 6'b000000, 1, 32'h3,         32'h28,        32'h7004};
      vecs[15] = '{0, 1, 5'd14, 32'h0000_5000, 32'd0,        0, 0,  1, 6'b000000, 0, 32'h1,         32'h28,        32'h5000};
      vecs[16] = '{0, 1, 5'd13, 32'hFFFF_FFFF, 32'd0,        0, 0,  0, 6'b000000, 0, 32'h1,         32'h28,        32'h5000};
      vecs[17] = '{1, 0, 5'd0,  32'd0,         32'h8000,     0, 12, 0, 6'b000000, 0, 32'h0,         32'h0,         32'h0};
      vecs[18] = '{0, 1, 5'd12, 32'hFFFF_FFFF, 32'd0,        0, 0,  0, 6'b000000, 0, 32'hFC03,      32'h0,         32'h0};

      reset = 1'b1;
      hw_int = 6'd0;
      idle_inputs();
      @(negedge clk);

      for (int i = 0; i < 19; i++) begin
         reset       = vecs[i].rst;
         en          = vecs[i].en;
         cp0_addr    = vecs[i].addr;
         cp0_wdata   = vecs[i].wdata;
         vpc         = vecs[i].vpc;
         bd_in       = vecs[i].bd;
         exc_code_in = vecs[i].exc;
         eret        = vecs[i].eret;
         hw_int      = vecs[i].hw;
         #1;
         if (!vecs[i].rst)
            check32($sformatf("req[%0d]", i), {31'd0, req}, {31'd0, vecs[i].exp_req});
         @(posedge clk);
         #1;
         reset = 1'b0;
         idle_inputs();
         cp0_addr = REG_SR;
         #1 check32($sformatf("sr[%0d]", i), cp0_rdata, vecs[i].exp_sr);
         cp0_addr = REG_CAUSE;
         #1 check32($sformatf("cause[%0d]", i), cp0_rdata, vecs[i].exp_cause);
         cp0_addr = REG_EPC;
         #1 check32($sformatf("epc[%0d]", i), cp0_rdata, vecs[i].exp_epc);
         check32($sformatf("epc_out[%0d]", i), epc_out, vecs[i].exp_epc);
         @(negedge clk);
      end

      // unmapped and PRId reads
      cp0_addr = 5'd0;
      #1 check32("rd_addr0", cp0_rdata, 32'd0);
      cp0_addr = 5'd11;
      #1 check32("rd_addr11", cp0_rdata, 32'd0);
`ifdef CP0_PRID_EN
      cp0_addr = REG_PRID;
      #1 check32("rd_prid", cp0_rdata, 32'h0000_4220);
`else
      cp0_addr = REG_PRID;
      #1 check32("rd_prid", cp0_rdata, 32'd0);
`endif

      // IE=1, IM=all, EXL=1: asserted hw_int must not raise req
      hw_int = 6'b100000;
      #1 check32("req_exl_masks_int", {31'd0, req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on posedge.
REQ-002 SHALL have: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: en  input  1  mtc0 write strobe from M stage.
REQ-004 SHALL have: cp0_addr  input  5  CP0 register number for read/write.
REQ-005 SHALL have: cp0_wdata  input  32  mtc0 write data.
REQ-006 SHALL have: cp0_rdata  output  32  mfc0 read data, combinational.
REQ-007 SHALL have: vpc  input  32  PC of instruction in M stage.
REQ-008 SHALL have: bd_in  input  1  M-stage instruction sits in a delay slot.
REQ-009 SHALL have: exc_code_in  input  5  M-stage exception code; 0 means none.
REQ-010 SHALL have: eret  input  1  eret in M stage.
REQ-011 SHALL have: hw_int  input  6  external interrupt lines, level-sensitive.
REQ-012 SHALL have: req  output  1  flush pipeline and redirect to handler (drives pipeline-register req).
REQ-013 SHALL have: epc_out  output  32  current EPC for eret redirect.

Function
REQ-014 SHALL implement SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-015 SHALL implement Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; not software-writable.
REQ-016 SHALL implement EPC (14): 32 bits, software-writable.
REQ-017 SHALL compute int_req = IE & ~EXL & |(hw_int & IM), combinationally.
REQ-018 SHALL compute exc_req = (exc_code_in != 0) & ~EXL, combinationally.
REQ-019 SHALL drive req = int_req | exc_req in the same cycle, with no register stage.
REQ-020 SHALL give the interrupt priority: if both are active, ExcCode = 0 (Int).
REQ-021 SHALL, on a posedge with req=1, set EXL=1, Cause.BD=bd_in, and Cause.ExcCode = int_req ? 0 : exc_code_in.
REQ-022 SHALL, on that same edge, set EPC = bd_in ? vpc-4 : vpc, with bits [1:0] forced to 0.
REQ-023 SHALL sample Cause.IP <= hw_int on every non-reset edge, regardless of req.
REQ-024 SHALL clear EXL on a posedge with eret=1 and req=0.
REQ-025 SHALL, on en=1 and req=0, write SR (addr 12) or EPC (addr 13/14 → EPC only at 14); writes to other addresses are ignored.
REQ-026 SHALL drop any mtc0 write or eret on an edge where req=1; the exception takes precedence.
REQ-027 SHALL return SR/Cause/EPC as registered on cp0_rdata, and 0 for unmapped addresses.
REQ-028 SHALL drive epc_out = EPC register, without forwarding from cp0_wdata.

Reset
REQ-029 SHALL clear SR, Cause, and EPC to 0 on reset; req is then 0 and epc_out is 0.
REQ-030 SHALL give reset priority over req, en, and eret on the same edge.

Configuration
REQ-031 SHALL, when CP0_PRID_EN is defined, map read-only PRId at addr 15, returning the package constant PRID_VALUE.
REQ-032 SHALL, without CP0_PRID_EN, read addr 15 as 0 and keep no PRId logic.

Structure
REQ-033 SHALL place in a shared package the register numbers (SR=12, CAUSE=13, EPC=14, PRID=15), the ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12), HANDLER_PC=32'h0000_4180, and PRID_VALUE.
REQ-034 SHALL be a single module with no sub-modules; the pipeline registers use the shared HANDLER_PC on req.

Verification
REQ-035 SHALL cover overflow: exc_code_in=12, vpc=0x3010, bd_in=0, EXL=0 → req=1 same cycle; next cycle EPC=0x3010, ExcCode=12, EXL=1.
REQ-036 SHALL cover delay slot: exc_code_in=4, vpc=0x3024, bd_in=1 → EPC=0x3020, BD=1.
REQ-037 SHALL cover interrupt: SR=0x0000_0401, hw_int=6'b000001 → req=1; ExcCode=0; with IE=0 or EXL=1 → req=0.
REQ-038 SHALL cover collision: en=1, addr=14, wdata=0x5000 in the same cycle as exc_code_in=10 → EPC=vpc, not 0x5000.
REQ-039 SHALL cover eret: eret=1 with EXL=1 → EXL=0 next cycle; a pending interrupt then asserts req.
REQ-040 SHALL cover reset mid-exception: reset=1 and req=1 on the same edge → SR/Cause/EPC=0.
